// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - start/length/data serial frame receiver with byte output
// Frame: start bit 0, 8-bit length N MSB first, then N data bits MSB first.
module serial_receiver (
    input  logic       clk,
    input  logic       rst,
    input  logic       serIn,
    output logic [7:0] ParOut,
    output logic       byte_valid,
    output logic [7:0] len_out,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, LEN, DATA, DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] len_reg_q, len_reg_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] shift_reg_q, shift_reg_d;
    logic [7:0] par_out_q, par_out_d;
    logic [7:0] len_out_q, len_out_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_valid_q, byte_valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [7:0] len_next;
    logic [7:0] shift_next;
    logic       rem_zero;

    assign len_next   = {len_reg_q[6:0], serIn};
    assign shift_next = {shift_reg_q[6:0], serIn};

    always_comb begin
        state_d      = state_q;
        len_reg_d    = len_reg_q;
        rem_d        = rem_q;
        shift_reg_d  = shift_reg_q;
        par_out_d    = par_out_q;
        len_out_d    = len_out_q;
        bit_cnt_d    = bit_cnt_q;
        byte_valid_d = 1'b0;
        done_d       = 1'b0;
        rem_zero     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!serIn) begin
                    state_d     = LEN;
                    bit_cnt_d   = 3'd0;
                    len_reg_d   = 8'd0;
                    shift_reg_d = 8'd0;
                end
            end
            LEN: begin
                len_reg_d = len_next;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rem_d     = len_next;
                    len_out_d = len_next;
                    if (len_next == 8'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                rem_d     = (rem_q != 8'd0) ? rem_q - 8'd1 : 8'd0;
                rem_zero  = (rem_d == 8'd0);
                // A short final byte is flushed right-aligned alongside done.
                if (bit_cnt_q == 3'd7 || rem_zero) begin
                    par_out_d    = shift_next;
                    byte_valid_d = 1'b1;
                    shift_reg_d  = 8'd0;
                end else begin
                    shift_reg_d = shift_next;
                end
                if (rem_zero) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_reg_q    <= 8'd0;
            rem_q        <= 8'd0;
            shift_reg_q  <= 8'd0;
            par_out_q    <= 8'd0;
            len_out_q    <= 8'd0;
            bit_cnt_q    <= 3'd0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_reg_q    <= len_reg_d;
            rem_q        <= rem_d;
            shift_reg_q  <= shift_reg_d;
            par_out_q    <= par_out_d;
            len_out_q    <= len_out_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ParOut     = par_out_q;
    assign byte_valid = byte_valid_q;
    assign len_out    = len_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule
